mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multicycle main control FSM for the CPU datapath.
- Generates `alu_op` for `alu_control`: 00 = add, 01 = sub, 10 = use the funct field.
- Also generates every datapath enable and mux select for each instruction phase.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB per opcode and stalls on a memory-ready handshake.

Parameters:
- `STATE_W`, 4, width of the state register / `state` debug port.

Ports:
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `opcode`  input  6  instruction[31:26] from the IR; stable from DECODE onward
- `mem_ready`  input  1  memory completes the current read/write this cycle
- `pc_write`  output  1  unconditional PC load
- `pc_write_cond`  output  1  PC load if ALU zero
- `i_or_d`  output  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  output  1  memory read request
- `mem_write`  output  1  memory write request
- `ir_write`  output  1  instruction register load
- `mem_to_reg`  output  1  write-back select: 1 = MDR, 0 = ALUOut
- `reg_dst`  output  1  destination register: 1 = rd, 0 = rt
- `reg_write`  output  1  register file write enable
- `alu_src_a`  output  1  0 = PC, 1 = A
- `alu_src_b`  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alu_op`  output  2  to `alu_control`
- `pc_source`  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal_op`  output  1  one-cycle pulse, unsupported opcode
- `state`  output  `STATE_W`  current state (debug)

Behaviour:
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000 (optional).
- Outputs are a Moore decode of `state`, except the `mem_ready`-qualified enables noted below. Any unlisted output is 0 in that state.
- Reset: `rst_n` low asynchronously forces state = FETCH and `illegal_op` = 0.
  - While `rst_n` is low, `pc_write`, `pc_write_cond`, `ir_write`, `reg_write` and `mem_write` are forced to 0.
  - Reset asserted mid-instruction abandons that instruction.
  - First FETCH begins on the first rising edge after release.
- FETCH:
  - `mem_read` = 1, `i_or_d` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00, `pc_source` = 00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready` = 0; goes to DECODE when `mem_ready` = 1.
- DECODE:
  - `alu_src_a` = 0, `alu_src_b` = 11, `alu_op` = 00 (branch target into ALUOut).
  - Next state: LW/SW → MEM_ADDR; R → EXECUTE; BEQ → BRANCH; J → JUMP.
  - Any other opcode → FETCH, and `illegal_op` is registered high for exactly the next cycle.
- MEM_ADDR:
  - `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00.
  - Next state: LW → MEM_RD, SW → MEM_WR.
- MEM_RD:
  - `mem_read` = 1, `i_or_d` = 1.
  - Holds until `mem_ready`, then → MEM_WB.
- MEM_WB:
  - `reg_write` = 1, `mem_to_reg` = 1, `reg_dst` = 0.
  - → FETCH.
- MEM_WR:
  - `mem_write` = 1, `i_or_d` = 1, held continuously until `mem_ready`.
  - On `mem_ready` → FETCH.
- EXECUTE:
  - `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10.
  - → R_WB.
- R_WB:
  - `reg_write` = 1, `reg_dst` = 1, `mem_to_reg` = 0.
  - → FETCH.
- BRANCH:
  - `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01.
  - → FETCH.
- JUMP:
  - `pc_write` = 1, `pc_source` = 10.
  - → FETCH.
- Unused state encodings → FETCH on the next edge; outputs are all 0 while in them.
- Instruction latency with `mem_ready` tied high, FETCH to next FETCH:
  - R: 4 cycles; LW: 5; SW: 4; BEQ: 3; J: 3.
  - Each low cycle of `mem_ready` in FETCH/MEM_RD/MEM_WR adds one cycle.
- `opcode` is ignored outside DECODE and MEM_ADDR.

Optional Feature:
- Macro: `MC_CONTROL_ADDI_EN`.
- When defined: opcode 001000 is legal.
  - DECODE → ADDI_EX (`alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00).
  - ADDI_EX → ADDI_WB (`reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 0).
  - ADDI_WB → FETCH. Total 4 cycles.
- When undefined: 001000 is illegal (`illegal_op` pulse, return to FETCH), and the ADDI states do not exist.

Test Plan:
- Reset low for 3 cycles with `mem_ready` = 1 → `state` = FETCH; `ir_write`, `pc_write`, `reg_write`, `mem_write` = 0 throughout; release → `ir_write` = 1 on the first edge.
- `opcode` = 000000, `mem_ready` = 1 → states FETCH, DECODE, EXECUTE, R_WB, FETCH; `alu_op` = 10 only in EXECUTE; `reg_dst` = `reg_write` = 1 in R_WB.
- `opcode` = 100011, `mem_ready` low 2 cycles in MEM_RD → 7-cycle instruction; `mem_read` = `i_or_d` = 1 for 3 cycles; `mem_to_reg` = 1 in MEM_WB.
- `opcode` = 101011, `mem_ready` low 1 cycle in FETCH → `ir_write` stays 0 for that cycle; `mem_write` held 1 in MEM_WR until `mem_ready`; total 5 cycles.
- `opcode` = 000100 then 000010 → BRANCH shows `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01; JUMP shows `pc_write` = 1, `pc_source` = 10; each 3 cycles.
- `opcode` = 111111 → DECODE goes to FETCH, `illegal_op` = 1 for exactly one cycle; `opcode` = 001000 repeats this without the macro, and takes the 4-cycle ADDI path with it.

Source files
------------

// File: rtl/mc_main_control.sv
`default_nettype none
//==============================================================================
// mc_main_control : multicycle CPU main control FSM (ADDI path: MC_CONTROL_ADDI_EN)
// Revision 1.0
//==============================================================================
module mc_main_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEM_ADDR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_RD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTE  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_R_WB     = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(9);
`ifdef MC_CONTROL_ADDI_EN
  localparam logic [STATE_W-1:0] S_ADDI_EX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDI_WB  = STATE_W'(11);
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               r_illegal;
  logic               w_illegal;

  logic       w_pc_write, w_pc_write_cond, w_mem_write, w_ir_write, w_reg_write;
  logic       w_i_or_d, w_mem_read, w_mem_to_reg, w_reg_dst, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      w_next = S_ADDI_EX;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      // Opcode is stable by now; anything other than LW/SW here is treated as abandoned.
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next = S_MEM_RD;
        else if (opcode == OP_SW) w_next = S_MEM_WR;
        else                      w_next = S_FETCH;
      end
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXECUTE:  w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
`ifdef MC_CONTROL_ADDI_EN
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
    end
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
      end
      S_DECODE:   w_alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDI_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDI_WB:  w_reg_write = 1'b1;
`endif
      default: ;
    endcase
  end

  // State-changing enables are held off combinationally for the whole reset window.
  assign pc_write      = w_pc_write      & rst_n;
  assign pc_write_cond = w_pc_write_cond & rst_n;
  assign ir_write      = w_ir_write      & rst_n;
  assign reg_write     = w_reg_write     & rst_n;
  assign mem_write     = w_mem_write     & rst_n;
  assign i_or_d        = w_i_or_d;
  assign mem_read      = w_mem_read;
  assign mem_to_reg    = w_mem_to_reg;
  assign reg_dst       = w_reg_dst;
  assign alu_src_a     = w_alu_src_a;
  assign alu_src_b     = w_alu_src_b;
  assign alu_op        = w_alu_op;
  assign pc_source     = w_pc_source;
  assign illegal_op    = r_illegal;
  assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
//==============================================================================
// tb_mc_main_control : directed cycle-by-cycle scoreboard bench for mc_main_control
// Revision 1.0
//==============================================================================
module tb_mc_main_control;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3;
  localparam logic [3:0] MEM_WB = 4'd4, MEM_WR = 4'd5, EXECUTE = 4'd6, R_WB = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [20:0] sb[$];

  mc_main_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Packed as {state, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aluop, pcsrc, ill}
  function automatic logic [20:0] expv(input logic [3:0] st, input logic mr,
                                       input logic in_rst, input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      FETCH:    begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      DECODE:   srcb = 2'b11;
      MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      MEM_RD:   begin mrd = 1; iord = 1; end
      MEM_WB:   begin rwr = 1; m2r = 1; end
      MEM_WR:   begin mwr = 1; iord = 1; end
      EXECUTE:  begin srca = 1; aop = 2'b10; end
      R_WB:     begin rwr = 1; rdst = 1; end
      BRANCH:   begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      JUMP:     begin pcw = 1; pcs = 2'b10; end
      ADDI_EX:  begin srca = 1; srcb = 2'b10; end
      ADDI_WB:  rwr = 1;
      default: ;
    endcase
    if (in_rst) begin pcw = 0; pcwc = 0; irw = 0; rwr = 0; mwr = 0; end
    return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, pcs, ill};
  endfunction

  task automatic cyc(input logic [3:0] st, input logic mr, input logic [5:0] op,
                     input logic ill, input string tag);
    logic [20:0] e, o;
    mem_ready = mr;
    opcode    = op;
    sb.push_back(expv(st, mr, ~rst_n, ill));
    @(negedge clk);
    e = sb.pop_front();
    o = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) cyc(FETCH, 1'b1, 6'b000000, 1'b0, "reset");
    rst_n = 1'b1;

    cyc(FETCH,   1, 6'b000000, 0, "r_fetch");
    cyc(DECODE,  1, 6'b000000, 0, "r_decode");
    cyc(EXECUTE, 1, 6'b000000, 0, "r_exec");
    cyc(R_WB,    1, 6'b000000, 0, "r_wb");

    cyc(FETCH,    1, 6'b100011, 0, "lw_fetch");
    cyc(DECODE,   1, 6'b100011, 0, "lw_decode");
    cyc(MEM_ADDR, 1, 6'b100011, 0, "lw_addr");
    cyc(MEM_RD,   0, 6'b100011, 0, "lw_rd_wait0");
    cyc(MEM_RD,   0, 6'b100011, 0, "lw_rd_wait1");
    cyc(MEM_RD,   1, 6'b100011, 0, "lw_rd_done");
    cyc(MEM_WB,   1, 6'b100011, 0, "lw_wb");

    cyc(FETCH,    0, 6'b101011, 0, "sw_fetch_wait");
    cyc(FETCH,    1, 6'b101011, 0, "sw_fetch");
    cyc(DECODE,   1, 6'b101011, 0, "sw_decode");
    cyc(MEM_ADDR, 1, 6'b101011, 0, "sw_addr");
    cyc(MEM_WR,   1, 6'b101011, 0, "sw_wr");

    cyc(FETCH,    1, 6'b101011, 0, "sw2_fetch");
    cyc(DECODE,   1, 6'b101011, 0, "sw2_decode");
    cyc(MEM_ADDR, 1, 6'b101011, 0, "sw2_addr");
    cyc(MEM_WR,   0, 6'b101011, 0, "sw2_wr_hold");
    cyc(MEM_WR,   1, 6'b101011, 0, "sw2_wr_done");

    cyc(FETCH,  1, 6'b000100, 0, "beq_fetch");
    cyc(DECODE, 1, 6'b000100, 0, "beq_decode");
    cyc(BRANCH, 1, 6'b000100, 0, "beq_branch");
    cyc(FETCH,  1, 6'b000010, 0, "j_fetch");
    cyc(DECODE, 1, 6'b000010, 0, "j_decode");
    cyc(JUMP,   1, 6'b000010, 0, "j_jump");

    cyc(FETCH,  1, 6'b111111, 0, "ill_fetch");
    cyc(DECODE, 1, 6'b111111, 0, "ill_decode");
    cyc(FETCH,  0, 6'b111111, 1, "ill_pulse");
    cyc(FETCH,  1, 6'b111111, 0, "ill_pulse_end");

    cyc(DECODE, 1, 6'b001000, 0, "addi_decode");
`ifdef MC_CONTROL_ADDI_EN
    cyc(ADDI_EX, 1, 6'b001000, 0, "addi_ex");
    cyc(ADDI_WB, 1, 6'b001000, 0, "addi_wb");
    cyc(FETCH,   0, 6'b001000, 0, "addi_done");
`else
    cyc(FETCH,   0, 6'b001000, 1, "addi_ill_pulse");
    cyc(FETCH,   0, 6'b001000, 0, "addi_ill_end");
`endif

    // Reset asserted mid-instruction abandons it.
    cyc(FETCH,    1, 6'b100011, 0, "abort_fetch");
    cyc(DECODE,   1, 6'b100011, 0, "abort_decode");
    rst_n = 1'b0;
    cyc(FETCH,    1, 6'b100011, 0, "abort_in_reset");
    rst_n = 1'b1;
    cyc(FETCH,    1, 6'b100011, 0, "abort_refetch");
    cyc(DECODE,   1, 6'b100011, 0, "abort_redecode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
